// File: rtl/eth10_pkg.sv
// Shared types and derived constants for the 10BASE-T receive path.
package eth10_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  // Last two bits of the SFD; the preamble alternates, so "11" marks frame start.
  localparam logic [1:0] SFD_LAST2 = 2'b11;

  function automatic int mid_min(input int clk_per_bit);
    return (3 * clk_per_bit) / 4;
  endfunction

  function automatic int idle_tmo(input int clk_per_bit);
    return (3 * clk_per_bit) / 2;
  endfunction

  function automatic int timer_w(input int link_tmo);
    return $clog2(link_tmo + 1);
  endfunction

endpackage

// File: rtl/eth10base_t_rx_manch_dec.sv
// Manchester decoder: synchronizes the line, classifies transitions as
// mid-bit or bit-boundary by spacing, and flags line silence.
module manch_dec
  import eth10_pkg::*;
#(
  parameter int CLK_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  input  logic idle_i,
  output logic bit_valid_o,
  output logic bit_val_o,
  output logic idle_tmo_o
);

  localparam int MID_MIN  = mid_min(CLK_PER_BIT);
  localparam int IDLE_TMO = idle_tmo(CLK_PER_BIT);
  localparam int CW       = $clog2(IDLE_TMO + 1);
  localparam logic [CW-1:0] MID_C  = CW'(MID_MIN);
  localparam logic [CW-1:0] IDLE_C = CW'(IDLE_TMO);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_val_q, bit_val_d;
  logic          idle_tmo_q, idle_tmo_d;
  logic          edge_s, accept_s;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    edge_s      = rx_sync_q ^ rx_prev_q;
    accept_s    = edge_s && (idle_i || (cnt_q >= MID_C));
    bit_valid_d = accept_s;
    bit_val_d   = rx_sync_q;
    idle_tmo_d  = 1'b0;
    cnt_d       = cnt_q;
    if (accept_s) begin
      // Loaded with 1 so that cnt_q equals the clock spacing at the next edge.
      cnt_d = CW'(1);
    end else if (cnt_q != IDLE_C) begin
      cnt_d      = cnt_q + 1'b1;
      idle_tmo_d = (cnt_d == IDLE_C);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      cnt_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_val_q   <= 1'b0;
      idle_tmo_q  <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      cnt_q       <= cnt_d;
      bit_valid_q <= bit_valid_d;
      bit_val_q   <= bit_val_d;
      idle_tmo_q  <= idle_tmo_d;
    end
  end

  assign bit_valid_o = bit_valid_q;
  assign bit_val_o   = bit_val_q;
  assign idle_tmo_o  = idle_tmo_q;

endmodule

// File: rtl/eth10base_t_rx.sv
// 10BASE-T receiver top: preamble/SFD hunt, byte assembly, end-of-frame
// reporting, NLP-based link integrity and the activity LED.
module eth10base_t_rx
  import eth10_pkg::*;
#(
  parameter int CLK_PER_BIT = 8,
  parameter int LINK_TMO    = 12_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_sof,
  output logic       rx_eof,
  output logic       rx_err,
  output logic       link_ok,
  output logic       Led_Rx
);

  localparam int TW = timer_w(LINK_TMO);
  localparam logic [TW-1:0] LINK_TMO_C = TW'(LINK_TMO);

  logic bit_valid, bit_val, idle_tmo;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          prev_bit_q, prev_bit_d;
  logic [1:0]    pre_bits_q, pre_bits_d;
  logic          sof_pend_q, sof_pend_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_sof_q, rx_sof_d;
  logic          rx_eof_q, rx_eof_d;
  logic          rx_err_q, rx_err_d;
  logic          link_ok_q, link_ok_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          led_q, led_d;
  logic          nlp_s, reload_s;

  manch_dec #(.CLK_PER_BIT(CLK_PER_BIT)) u_dec (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_i       (Rx),
    .idle_i     (state_q == ST_IDLE),
    .bit_valid_o(bit_valid),
    .bit_val_o  (bit_val),
    .idle_tmo_o (idle_tmo)
  );

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    prev_bit_d = prev_bit_q;
    pre_bits_d = pre_bits_q;
    sof_pend_d = sof_pend_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_sof_d   = 1'b0;
    rx_eof_d   = 1'b0;
    rx_err_d   = 1'b0;
    nlp_s      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bit_valid) begin
          state_d    = ST_PRE;
          prev_bit_d = bit_val;
          pre_bits_d = 2'd0;
        end
      end
      ST_PRE: begin
        if (idle_tmo) begin
          state_d = ST_IDLE;
          // A lone pulse decodes as its rising bit plus at most one more.
          nlp_s   = (pre_bits_q < 2'd2);
        end else if (bit_valid) begin
          prev_bit_d = bit_val;
          if (pre_bits_q != 2'd2) pre_bits_d = pre_bits_q + 1'b1;
          if ({prev_bit_q, bit_val} == SFD_LAST2) begin
            state_d    = ST_DATA;
            bitcnt_d   = 3'd0;
            sof_pend_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (idle_tmo) begin
          state_d  = ST_IDLE;
          rx_eof_d = 1'b1;
          rx_err_d = (bitcnt_q != 3'd0);
        end else if (bit_valid) begin
          shift_d  = {bit_val, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
            rx_sof_d   = sof_pend_q;
            sof_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    led_d     = (state_d != ST_DATA);
    reload_s  = nlp_s || (rx_eof_d && !rx_err_d);
    timer_d   = timer_q;
    link_ok_d = link_ok_q;
    // Reload takes priority so a coincident expiry cannot drop the link.
    if (reload_s) begin
      timer_d   = '0;
      link_ok_d = 1'b1;
    end else if (timer_q != LINK_TMO_C) begin
      timer_d = timer_q + 1'b1;
      if (timer_d == LINK_TMO_C) link_ok_d = 1'b0;
    end
  end

  // NOTE: all control and datapath registers are reset explicitly, so a
  // reset mid-frame discards the partial byte and suppresses any end-of-frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      prev_bit_q <= 1'b0;
      pre_bits_q <= 2'd0;
      sof_pend_q <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      rx_sof_q   <= 1'b0;
      rx_eof_q   <= 1'b0;
      rx_err_q   <= 1'b0;
      link_ok_q  <= 1'b0;
      timer_q    <= '0;
      led_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      prev_bit_q <= prev_bit_d;
      pre_bits_q <= pre_bits_d;
      sof_pend_q <= sof_pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_sof_q   <= rx_sof_d;
      rx_eof_q   <= rx_eof_d;
      rx_err_q   <= rx_err_d;
      link_ok_q  <= link_ok_d;
      timer_q    <= timer_d;
      led_q      <= led_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_sof   = rx_sof_q;
  assign rx_eof   = rx_eof_q;
  assign rx_err   = rx_err_q;
  assign link_ok  = link_ok_q;
  assign Led_Rx   = led_q;

endmodule

// File: tb/tb_eth10base_t_rx.sv
// Scoreboard bench for eth10base_t_rx: Manchester frames and link pulses are
// driven on Rx, expected bytes/eofs are queued and compared as they appear.
`timescale 1ns/1ps
module tb_eth10base_t_rx;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  localparam int TMO  = 1000;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
  } exp_byte_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_sof, rx_eof, rx_err, link_ok, Led_Rx;

  exp_byte_t  exp_q[$];
  logic       eof_q[$];
  bit         tx_bits[$];
  logic [7:0] frame_bytes[8];

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_eof    = 0;

  eth10base_t_rx #(.CLK_PER_BIT(CPB), .LINK_TMO(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Rx      (Rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_sof  (rx_sof),
    .rx_eof  (rx_eof),
    .rx_err  (rx_err),
    .link_ok (link_ok),
    .Led_Rx  (Led_Rx)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Output monitor: pops the scoreboard on every strobe.
  always @(negedge clk) begin
    exp_byte_t e;
    logic      ee;
    if (rx_valid) begin
      n_valid++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: got data=%02h sof=%0b, none expected", rx_data, rx_sof);
      end else begin
        e = exp_q.pop_front();
        if (rx_data !== e.data || rx_sof !== e.sof) begin
          n_fail++;
          $display("FAIL byte: got data=%02h sof=%0b, expected data=%02h sof=%0b",
                   rx_data, rx_sof, e.data, e.sof);
        end
      end
    end
    if (rx_eof) begin
      n_eof++;
      n_checks++;
      if (eof_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_eof: got err=%0b, none expected", rx_err);
      end else begin
        ee = eof_q.pop_front();
        if (rx_err !== ee || rx_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL eof: got err=%0b valid=%0b, expected err=%0b valid=0", rx_err, rx_valid, ee);
        end
      end
    end
  end

  task automatic drive_level(input logic lvl, input int nclk);
    Rx = lvl;
    repeat (nclk) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_clks(input int n);
    drive_level(1'b0, n);
  endtask

  // Builds preamble + SFD + data + dribble bits, drives them Manchester-coded
  // (first half ~b, second half b) and queues the expected results.
  task automatic send_frame(input int nbytes, input int dribble, input bit noise,
                            input bit jit, input int rst_bit);
    logic [7:0] sfd;
    bit         b;
    bit         aborted;
    int         j;
    int         di;
    sfd = 8'hD5;
    aborted = 1'b0;
    tx_bits.delete();
    for (int k = 0; k < 56; k++) tx_bits.push_back((k % 2) == 0);
    if (noise) begin
      tx_bits[54] = 1'b0;
      tx_bits[55] = 1'b0;
    end
    for (int k = 0; k < 8; k++) tx_bits.push_back(sfd[k]);
    for (int n = 0; n < nbytes; n++)
      for (int k = 0; k < 8; k++) tx_bits.push_back(frame_bytes[n][k]);
    for (int k = 0; k < dribble; k++) tx_bits.push_back((k % 2) == 0);

    for (int i = 0; i < tx_bits.size(); i++) begin
      b  = tx_bits[i];
      di = i - 64;
      if (!aborted && di >= 0 && (di % 8) == 7 && (di / 8) < nbytes) begin
        exp_q.push_back('{data: frame_bytes[di / 8], sof: (di / 8) == 0});
        n_checks++;
        if (Led_Rx !== 1'b0) begin
          n_fail++;
          $display("FAIL led_in_data: got Led_Rx=%0b, expected 0", Led_Rx);
        end
      end
      j = jit ? (int'($urandom_range(2)) - 1) : 0;
      if (i == rst_bit) begin
        Rx = ~b;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        aborted = 1'b1;
        n_checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_err, link_ok, Led_Rx} !== 14'b00000000_000001) begin
          n_fail++;
          $display("FAIL midframe_reset_outputs: got data=%02h v=%0b sof=%0b eof=%0b err=%0b link=%0b led=%0b, expected all 0 led=1",
                   rx_data, rx_valid, rx_sof, rx_eof, rx_err, link_ok, Led_Rx);
        end
        drive_level(~b, HALF + j - 1);
      end else begin
        drive_level(~b, HALF + j);
      end
      drive_level(b, HALF - j);
    end
    if (!aborted) eof_q.push_back(dribble != 0);
    if (Rx) drive_level(1'b0, HALF);
    idle_clks(40);
  endtask

  task automatic check_drained(input string name, input int valid0, input int nexp);
    n_checks++;
    if (exp_q.size() != 0 || eof_q.size() != 0 || (n_valid - valid0) != nexp) begin
      n_fail++;
      $display("FAIL %s_drained: got %0d bytes, %0d/%0d left in queues, expected %0d bytes and empty queues",
               name, n_valid - valid0, exp_q.size(), eof_q.size(), nexp);
      exp_q.delete();
      eof_q.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 4;
    if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h, expected 00", rx_data); end
    if ({rx_valid, rx_sof, rx_eof, rx_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %04b, expected 0000", {rx_valid, rx_sof, rx_eof, rx_err});
    end
    if (link_ok !== 1'b0) begin n_fail++; $display("FAIL reset_link: got %0b, expected 0", link_ok); end
    if (Led_Rx !== 1'b1) begin n_fail++; $display("FAIL reset_led: got %0b, expected 1", Led_Rx); end
    rst_n = 1'b1;
    idle_clks(20);
  endtask

  task automatic test_basic_frame;
    int v0;
    v0 = n_valid;
    frame_bytes[0] = 8'h55; frame_bytes[1] = 8'hAA; frame_bytes[2] = 8'h01;
    send_frame(3, 0, 1'b0, 1'b0, -1);
    check_drained("basic", v0, 3);
    n_checks++;
    if (link_ok !== 1'b1) begin n_fail++; $display("FAIL basic_link: got %0b, expected 1", link_ok); end
    n_checks++;
    if (Led_Rx !== 1'b1) begin n_fail++; $display("FAIL basic_led_idle: got %0b, expected 1", Led_Rx); end
  endtask

  task automatic test_dribble;
    int   v0;
    logic link0;
    v0 = n_valid;
    link0 = link_ok;
    send_frame(3, 3, 1'b0, 1'b0, -1);
    check_drained("dribble", v0, 3);
    n_checks++;
    if (link_ok !== link0) begin n_fail++; $display("FAIL dribble_link: got %0b, expected %0b", link_ok, link0); end
  endtask

  task automatic test_nlp;
    int n;
    int v0, e0;
    v0 = n_valid;
    e0 = n_eof;
    n = 0;
    while (link_ok === 1'b1 && n < 1500) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (link_ok !== 1'b0) begin n_fail++; $display("FAIL link_drop_wait: got %0b, expected 0", link_ok); end
    drive_level(1'b1, CPB);
    drive_level(1'b0, 1);
    n = 0;
    while (link_ok !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (link_ok !== 1'b1) begin n_fail++; $display("FAIL nlp_link_up: got %0b, expected 1", link_ok); end
    n = 0;
    while (link_ok === 1'b1 && n < 1100) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (n != TMO) begin n_fail++; $display("FAIL link_tmo_clocks: got %0d, expected %0d", n, TMO); end
    for (int k = 0; k < 3; k++) begin
      drive_level(1'b1, CPB);
      drive_level(1'b0, 600);
      n_checks++;
      if (link_ok !== 1'b1) begin n_fail++; $display("FAIL nlp_keep_%0d: got %0b, expected 1", k, link_ok); end
    end
    n_checks++;
    if (n_valid != v0 || n_eof != e0) begin
      n_fail++; $display("FAIL nlp_no_frame: got %0d bytes %0d eofs, expected 0 0", n_valid - v0, n_eof - e0);
    end
  endtask

  task automatic test_phase_jitter;
    int v0;
    frame_bytes[0] = 8'h55; frame_bytes[1] = 8'hAA; frame_bytes[2] = 8'h01;
    frame_bytes[3] = 8'hFF; frame_bytes[4] = 8'h00; frame_bytes[5] = 8'h3C;
    for (int ph = 0; ph < CPB; ph++) begin
      v0 = n_valid;
      idle_clks(ph + 1);
      send_frame(6, 0, 1'b0, 1'b1, -1);
      check_drained($sformatf("phase%0d", ph), v0, 6);
    end
  endtask

  task automatic test_reset_midframe;
    int v0;
    v0 = n_valid;
    frame_bytes[0] = 8'h55; frame_bytes[1] = 8'h55; frame_bytes[2] = 8'h55;
    // Bit 2 of the second byte is a '1', so the line is low when reset hits.
    send_frame(3, 0, 1'b0, 1'b0, 64 + 8 + 2);
    check_drained("reset_mid", v0, 1);
    v0 = n_valid;
    frame_bytes[0] = 8'h55; frame_bytes[1] = 8'hAA; frame_bytes[2] = 8'h01;
    send_frame(3, 0, 1'b0, 1'b0, -1);
    check_drained("after_reset", v0, 3);
  endtask

  task automatic test_preamble_noise;
    int v0;
    v0 = n_valid;
    frame_bytes[0] = 8'hA7; frame_bytes[1] = 8'h42;
    send_frame(2, 0, 1'b1, 1'b0, -1);
    check_drained("noise", v0, 2);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_dribble();
    test_nlp();
    test_phase_jitter();
    test_reset_midframe();
    test_preamble_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth10base_t_rx.md
# eth10base_t_rx

10BASE-T receive path, the counterpart to the transmit chain. It oversamples the single-ended receive comparator output, Manchester-decodes it, and hunts preamble/SFD. It then delivers frame bytes LSB-first-assembled on a valid/sof/eof strobe interface and tracks link integrity from normal link pulses (NLP). It sits between the line-receiver pin and the frame-level MAC logic, and drives an active-low activity LED like the transmit side.

## Interface
- CLK_PER_BIT, 8: sampling clocks per 100 ns bit time; must be even and ≥ 6
- LINK_TMO, 12_000_000: clocks without NLP or good frame before link_ok drops (150 ms at 80 MHz)
- clk  in  1  sampling clock, CLK_PER_BIT × 10 MHz; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- Rx  in  1  asynchronous line-receiver output (1 = positive differential)
- rx_data  out  8  received byte, valid while rx_valid
- rx_valid  out  1  one-cycle strobe per byte
- rx_sof  out  1  high with rx_valid on the first byte after SFD
- rx_eof  out  1  one-cycle strobe at end of frame, never coincident with rx_valid
- rx_err  out  1  high with rx_eof when the frame ended on a non-byte boundary
- link_ok  out  1  link integrity status
- Led_Rx  out  1  active-low: 0 while in DATA state

## Operation
- Rx passes through a 2-FF synchronizer (reset 0), then a registered copy for edge detect.
- Decoder: `cnt` counts clocks since the last accepted mid-bit transition and saturates. A transition with cnt ≥ 3·CLK_PER_BIT/4 is a mid-bit transition: bit = new line level (0→1 = '1'), cnt←0. Transitions with cnt below that value are bit-boundary transitions and are ignored. In IDLE, the first transition is taken as mid-bit.
- Idle timeout: cnt reaches 3·CLK_PER_BIT/2 with no accepted transition.
- FSM states IDLE, PRE, DATA:
  - IDLE: transition → PRE (that transition yields bit 0 of the bit count). Idle timeout → stay in IDLE.
  - PRE: track the previous bit. Bits "11" → DATA, bit counter ← 0. Idle timeout → IDLE. If ≤ 1 bit was decoded since leaving IDLE, this counts as a valid NLP.
  - DATA: shift bits into the top of the shift register (LSB first on wire). On the 8th bit: rx_data ← byte, rx_valid pulse, rx_sof on the first byte only, counter wraps to 0. Idle timeout → rx_eof pulse, rx_err = (counter ≠ 0), partial byte discarded, → IDLE.
- Link: timer reloads on a valid NLP or an rx_eof with rx_err = 0. link_ok ← 1 on reload. link_ok ← 0 when the timer reaches LINK_TMO; the timer then saturates.
- Simultaneous events: a byte completion and an idle timeout cannot coincide, because the timeout requires no accepted transition. A reload on the same cycle as expiry wins, so link_ok stays 1.

## Timing
- Reset values: rx_data 0, rx_valid 0, rx_sof 0, rx_eof 0, rx_err 0, link_ok 0, Led_Rx 1, state IDLE, timer 0.
- Reset mid-frame: all outputs take reset values on the next edge. No eof is emitted.
- Latency: rx_valid rises 4 clocks after the Rx pin edge carrying the 8th bit (2 sync + 1 edge + 1 output register).
- rx_eof rises 3·CLK_PER_BIT/2 + 1 clocks after the last accepted mid-bit transition.
- All outputs are registered. Strobes last exactly one cycle. There is no backpressure: the consumer must accept every strobe.
- Bytes are at least 8·CLK_PER_BIT clocks apart.

## Structure
- Shared package eth10_pkg: state enum (IDLE/PRE/DATA), SFD_LAST2 = 2'b11, derived constants MID_MIN = 3·CLK_PER_BIT/4 and IDLE_TMO = 3·CLK_PER_BIT/2, timer width $clog2(LINK_TMO+1).
- One sub-module, manch_dec: synchronizer, edge detect, cnt, and the bit_valid/bit_val/idle_tmo outputs.
- The top module holds the FSM, byte assembly, link timer and LED.

## Test plan
- 56 preamble bits + SFD 0xD5 + bytes 0x55, 0xAA, 0x01, then idle → exactly 3 rx_valid, data 0x55/0xAA/0x01, rx_sof on the first only, one rx_eof with rx_err = 0, link_ok = 1.
- Same frame with 3 dribble bits after 0x01 → 3 bytes, rx_eof with rx_err = 1, link_ok unchanged from its prior value.
- Single 100 ns positive pulse, then 16 ms idle, repeated → link_ok rises after the first pulse (timer reload) and no rx_valid/rx_eof. With LINK_TMO = 1000 and the pulses stopped, link_ok falls at exactly 1000 clocks.
- Sampling phase swept over 0..CLK_PER_BIT−1 and ±1-clock jitter on edges → identical byte stream in every case.
- rst_n low for 1 cycle in the middle of the second byte → all outputs at reset values the next cycle. The next full frame decodes correctly with rx_sof set.
- Preamble ending in "00" noise, then a valid SFD → no bytes before SFD, and the first byte after SFD is flagged sof.
